// File: rtl/ahb_pkg.sv
// Shared AHB slave definitions: transfer/response codes, peripheral address map
// and FSM state type. Used by ahb_slave_if and ahb_slv_decoder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SLV0 = 3'b001;
  localparam logic [2:0] SEL_SLV1 = 3'b010;
  localparam logic [2:0] SEL_SLV2 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_e;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/ahb_slv_decoder.sv
// Combinational address decoder: maps an AHB address onto the one-hot
// peripheral select and an in-map flag. No wrap handling; top of space is unmapped.
module ahb_slv_decoder
  import ahb_pkg::*;
(
  input  logic [31:0] i_haddr,
  output logic [2:0]  o_sel,
  output logic        o_inmap
);

  always_comb begin
    o_sel = SEL_NONE;
    if (in_range(i_haddr, SLV0_BASE, SLV0_LIMIT)) begin
      o_sel = SEL_SLV0;
    end else if (in_range(i_haddr, SLV1_BASE, SLV1_LIMIT)) begin
      o_sel = SEL_SLV1;
    end else if (in_range(i_haddr, SLV2_BASE, SLV2_LIMIT)) begin
      o_sel = SEL_SLV2;
    end
  end

  assign o_inmap = |o_sel;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end feeding an APB-style downstream: address/data pipeline,
// peripheral select and transfer FSM. Define AHB_SLV_ERR_EN for ERROR responses + timeout.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        ds_ready,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [2:0]  tempselx
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..256");
  end

  logic [2:0]  w_sel;
  logic        w_inmap;
  logic        w_trans_act;
  logic        w_hready;
  logic        w_accept;
  ahb_state_e  w_launch;

  ahb_state_e  r_state;
  logic        r_valid;
  logic [1:0]  r_hresp;
  logic [31:0] r_haddr1;
  logic [31:0] r_haddr2;
  logic [31:0] r_hwdata1;
  logic [31:0] r_hwdata2;
  logic        r_hwrite;
  logic [2:0]  r_sel;

`ifdef AHB_SLV_ERR_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] r_cnt;
`endif

  ahb_slv_decoder u_dec (
    .i_haddr (Haddr),
    .o_sel   (w_sel),
    .o_inmap (w_inmap)
  );

  assign w_trans_act = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);

  always_comb begin
    w_hready = 1'b1;
    unique case (r_state)
      ST_BUSY: w_hready = ds_ready;
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: w_hready = 1'b0;
`endif
      default: w_hready = 1'b1;
    endcase
  end

  // ERR2 drives HREADY high but must still refuse the address phase it overlaps
  assign w_accept = Hreadyin && w_hready && w_trans_act &&
                    ((r_state == ST_IDLE) || (r_state == ST_BUSY));

  always_comb begin
    w_launch = ST_IDLE;
    if (w_accept) begin
      if (w_inmap) begin
        w_launch = ST_BUSY;
      end
`ifdef AHB_SLV_ERR_EN
      else begin
        w_launch = ST_ERR1;
      end
`endif
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_haddr1  <= '0;
      r_haddr2  <= '0;
      r_hwdata1 <= '0;
      r_hwdata2 <= '0;
      r_hwrite  <= 1'b0;
      r_sel     <= SEL_NONE;
    end else if (Hreadyin) begin
      r_haddr1  <= Haddr;
      r_haddr2  <= r_haddr1;
      r_hwdata1 <= Hwdata;
      r_hwdata2 <= r_hwdata1;
      r_hwrite  <= Hwrite;
      r_sel     <= w_sel;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_hresp <= HRESP_OKAY;
`ifdef AHB_SLV_ERR_EN
      r_cnt   <= '0;
`endif
    end else begin
`ifdef AHB_SLV_ERR_EN
      r_cnt <= '0;
`endif
      unique case (r_state)
        ST_BUSY: begin
          if (ds_ready) begin
            r_state <= w_launch;
            r_valid <= (w_launch == ST_BUSY);
            r_hresp <= (w_launch == ST_ERR1) ? HRESP_ERROR : HRESP_OKAY;
          end
`ifdef AHB_SLV_ERR_EN
          else if (r_cnt == CNT_TOP) begin
            r_state <= ST_ERR1;
            r_valid <= 1'b0;
            r_hresp <= HRESP_ERROR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
`ifdef AHB_SLV_ERR_EN
        ST_ERR1: begin
          r_state <= ST_ERR2;
          r_valid <= 1'b0;
          r_hresp <= HRESP_ERROR;
        end
        ST_ERR2: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_hresp <= HRESP_OKAY;
        end
`endif
        default: begin
          r_state <= w_launch;
          r_valid <= (w_launch == ST_BUSY);
          r_hresp <= (w_launch == ST_ERR1) ? HRESP_ERROR : HRESP_OKAY;
        end
      endcase
    end
  end

  assign Hreadyout = w_hready;
  assign Hresp     = r_hresp;
  assign valid     = r_valid;
  assign Haddr1    = r_haddr1;
  assign Haddr2    = r_haddr2;
  assign Hwdata1   = r_hwdata1;
  assign Hwdata2   = r_hwdata2;
  assign Hwritereg = r_hwrite;
  assign tempselx  = r_sel;

endmodule

// File: doc/ahb_slave_if.md
AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 16, meaning the maximum data-phase wait cycles before an ERROR response (range 2..256).
REQ-002 SHALL provide ports, one clock, reset asynchronous and active-high:
- Hclk  input  1  bus clock; all state on rising edge.
- Hreset  input  1  asynchronous active-high reset.
- Hwrite  input  1  transfer direction from master (1 = write).
- Hreadyin  input  1  bus ready from master side.
- Htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Haddr  input  32  address-phase address.
- Hwdata  input  32  write data, valid one cycle after its address.
- ds_ready  input  1  downstream (APB side) ready for the current data phase.
- Hreadyout  output  1  slave ready to master.
- Hresp  output  2  response: 00 OKAY, 01 ERROR.
- valid  output  1  registered in-map transfer indication to downstream.
- Haddr1  output  32  address delayed 1 stage.
- Haddr2  output  32  address delayed 2 stages.
- Hwdata1  output  32  write data delayed 1 stage.
- Hwdata2  output  32  write data delayed 2 stages.
- Hwritereg  output  1  Hwrite delayed 1 stage.
- tempselx  output  3  one-hot peripheral select for Haddr1.

Function
REQ-003 SHALL treat a transfer as accepted when Hreadyin=1 and Hreadyout=1 and Htrans is 10 or 11; 00 and 01 are never accepted.
REQ-004 SHALL load Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite on every edge where Hreadyin=1; all hold when Hreadyin=0.
REQ-005 SHALL register tempselx from Haddr with the Haddr1 load: 0x8000_0000-0x83FF_FFFF -> 001, 0x8400_0000-0x87FF_FFFF -> 010, 0x8800_0000-0x8BFF_FFFF -> 100, otherwise 000.
REQ-006 SHALL assert valid for exactly the data-phase cycles (one cycle after acceptance, held through waits) of an accepted in-map transfer; valid=0 otherwise.
REQ-007 SHALL implement an FSM with states IDLE, BUSY, ERR1, ERR2.
REQ-008 IDLE: Hreadyout=1, Hresp=00; accepted in-map -> BUSY; accepted out-of-map -> ERR1.
REQ-009 BUSY: Hreadyout=ds_ready, Hresp=00; on ds_ready=1 go to BUSY if a new in-map transfer is accepted that cycle, ERR1 if out-of-map, else IDLE.
REQ-010 BUSY wait counter SHALL clear on entry and on ds_ready=1, increment each cycle with ds_ready=0, and on reaching TIMEOUT_CYC-1 force ERR1 next cycle.
REQ-011 ERR1: Hreadyout=0, Hresp=01, always -> ERR2; ERR2: Hreadyout=1, Hresp=01, always -> IDLE; no transfer is accepted in ERR1 or ERR2.
REQ-012 Back-to-back SEQ bursts SHALL sustain one transfer per cycle when ds_ready stays 1.
REQ-013 Address wrap from 0xFFFF_FFFF SHALL be handled only as an out-of-map address, with no special case.

Reset
REQ-014 Hreset=1 SHALL immediately force state IDLE, counter 0, Hreadyout=1, Hresp=00, valid=0, tempselx=000 and all pipeline registers to 0.
REQ-015 Reset mid-burst, mid-wait or mid-error SHALL abandon the transfer; the first edge after release behaves as IDLE.

Configuration
REQ-016 Macro AHB_SLV_ERR_EN defined: REQ-008 to REQ-011 error paths and the timeout counter are present.
REQ-017 Macro AHB_SLV_ERR_EN undefined: Hresp fixed 00, ERR1/ERR2 and the counter are absent, out-of-map transfers complete OKAY with valid=0, and BUSY waits indefinitely for ds_ready.

Structure
REQ-018 Package ahb_pkg SHALL hold the HTRANS and HRESP codes, the three address-range base/limit constants and the FSM state type.
REQ-019 A single combinational sub-module, ahb_slv_decoder, SHALL map Haddr to the tempselx code and an in-map flag.

Verification
REQ-020 Single write 0x8000_0001 / 0xA3, ds_ready=1 -> next cycle valid=1, tempselx=001, Hwritereg=1; following cycle Hwdata1=0xA3.
REQ-021 4-beat SEQ write 0x8400_0000..03, ds_ready=1 -> valid high 4 consecutive cycles, Hreadyout constant 1, tempselx=010.
REQ-022 Read 0x8800_0010 with ds_ready low 3 cycles -> Hreadyout=0 for 3 cycles, then 1; valid held 4 cycles.
REQ-023 Write 0x9000_0000 (ERR_EN) -> cycle 1 Hresp=01/Hreadyout=0, cycle 2 Hresp=01/Hreadyout=1, then IDLE with valid=0.
REQ-024 ds_ready held low with TIMEOUT_CYC=4 -> ERR1 entered after 4 wait cycles; repeat without ERR_EN -> Hreadyout stays 0, Hresp=00.
REQ-025 Hreset pulse during a BUSY wait -> Hreadyout=1, valid=0, Haddr1=0 asynchronously, before the next edge.
